mem_slave_rsp: RTL and testbench

- Parametrised single-port memory slave with a valid/ready request channel and an in-order response channel.
- Every request, read or write, returns exactly one response carrying a 2-bit error code.
- Address space decodes into three regions: backed storage, a reserved window, and unmapped space.
- After every reset an internal init sequencer fills the storage before requests are accepted; the block sits behind the testbench/interconnect as a generic slave.

---
 rtl/mem_slave_pkg.sv | 33 +++
 rtl/mem_slave_rsp_fifo.sv | 50 +++++
 rtl/mem_slave_rsp.sv | 193 +++++++++++++++++++
 tb/tb_mem_slave_rsp.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_slave_pkg.sv
// Shared types and the address-region decode helper for mem_slave_rsp.
package mem_slave_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    DECERR = 2'b01,
    SLVERR = 2'b10,
    RSVERR = 2'b11
  } rsp_err_e;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    REGION_MEM  = 2'b00,
    REGION_RSV  = 2'b01,
    REGION_NONE = 2'b10
  } region_e;

  localparam logic [31:0] RSV_PATTERN = 32'hDEADBEEF;

  function automatic region_e decode_region(input logic [31:0] addr,
                                            input int unsigned depth,
                                            input int unsigned rsv_lo,
                                            input int unsigned rsv_hi);
    if (addr < depth) return REGION_MEM;
    if ((addr >= rsv_lo) && (addr <= rsv_hi)) return REGION_RSV;
    return REGION_NONE;
  endfunction

endpackage

// File: rtl/mem_slave_rsp_fifo.sv
// Synchronous FIFO used as the in-order response queue; head is visible while not empty.
module mem_slave_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) store_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = store_q[rd_ptr_q];
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/mem_slave_rsp.sv
// Memory slave with region decode, post-reset init fill and a credit-limited in-order response queue.
// Define MEM_SLAVE_BYTE_STROBE_EN to add req_strb byte enables on OKAY writes.
// state | meaning
// INIT  | filling storage with INIT_VALUE, one word per cycle; requests blocked
// RUN   | accepting requests while response credits remain
module mem_slave_rsp
  import mem_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 61,
  parameter int RSV_LO     = 61,
  parameter int RSV_HI     = 64,
  parameter int RD_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
`ifdef MEM_SLAVE_BYTE_STROBE_EN
  input  logic [DATA_WIDTH/8-1:0] req_strb,
`endif
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_wr,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_err,
  output logic                  init_done
);

  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW      = $clog2(RD_LATENCY + 2);
  localparam int ENTRY_W = DATA_WIDTH + 3;
  localparam logic [CW-1:0] CREDITS_INIT = CW'(RD_LATENCY + 1);

  function automatic logic [DATA_WIDTH-1:0] rsv_fill();
    logic [DATA_WIDTH-1:0] v;
    for (int i = 0; i < DATA_WIDTH; i++) v[i] = RSV_PATTERN[i % 32];
    return v;
  endfunction

  localparam logic [DATA_WIDTH-1:0] RSV_DATA = rsv_fill();

  state_e                state_q;
  logic [IDX_W-1:0]      init_ptr_q;
  logic [CW-1:0]         credits_q;
  logic [CW-1:0]         credits_d;
  logic                  req_ready_q;
  logic                  init_done_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  accept;
  logic                  consume;
  region_e               region;
  rsp_err_e              acc_err;
  logic [DATA_WIDTH-1:0] acc_rdata;
  logic [IDX_W-1:0]      acc_idx;
  logic                  wr_en;
  logic [ENTRY_W-1:0]    acc_entry;
  logic                  push;
  logic [ENTRY_W-1:0]    push_entry;
  logic [ENTRY_W-1:0]    head_entry;
  logic                  fifo_empty;

  assign accept  = req_valid && req_ready_q;
  assign consume = rsp_valid && rsp_ready;
  assign acc_idx = req_addr[IDX_W-1:0];

  always_comb begin
    region    = decode_region(32'(req_addr), DEPTH, RSV_LO, RSV_HI);
    acc_err   = OKAY;
    acc_rdata = '0;
    case (region)
      REGION_MEM: begin
        acc_err = OKAY;
        if (!req_wr) acc_rdata = mem_q[acc_idx];
      end
      REGION_RSV: begin
        acc_err = RSVERR;
        if (!req_wr) acc_rdata = RSV_DATA;
      end
      default: acc_err = req_wr ? DECERR : SLVERR;
    endcase
  end

  assign wr_en     = accept && req_wr && (region == REGION_MEM);
  assign acc_entry = {req_wr, acc_err, acc_rdata};

  // Storage is not reset; INIT rewrites every word after each reset.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem_q[init_ptr_q] <= INIT_VALUE;
    end else if (wr_en) begin
`ifdef MEM_SLAVE_BYTE_STROBE_EN
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
        if (req_strb[b]) mem_q[acc_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
      end
`else
      mem_q[acc_idx] <= req_wdata;
`endif
    end
  end

  always_comb begin
    credits_d = credits_q;
    case ({accept, consume})
      2'b10:   credits_d = credits_q - 1'b1;
      2'b01:   credits_d = credits_q + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= INIT;
      init_ptr_q  <= '0;
      credits_q   <= CREDITS_INIT;
      req_ready_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          init_ptr_q <= init_ptr_q + 1'b1;
          if (init_ptr_q == IDX_W'(DEPTH - 1)) begin
            state_q     <= RUN;
            init_ptr_q  <= '0;
            init_done_q <= 1'b1;
            req_ready_q <= 1'b1;
          end
        end
        RUN: begin
          credits_q   <= credits_d;
          req_ready_q <= (credits_d != '0);
        end
      endcase
    end
  end

  // The FIFO push itself is the final latency stage, so only RD_LATENCY-1 registers sit ahead of it.
  generate
    if (RD_LATENCY == 1) begin : g_direct
      assign push       = accept;
      assign push_entry = acc_entry;
    end else begin : g_pipe
      logic               vld_q [RD_LATENCY-1];
      logic [ENTRY_W-1:0] dat_q [RD_LATENCY-1];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < RD_LATENCY - 1; i++) begin
            vld_q[i] <= 1'b0;
            dat_q[i] <= '0;
          end
        end else begin
          vld_q[0] <= accept;
          dat_q[0] <= acc_entry;
          for (int i = 1; i < RD_LATENCY - 1; i++) begin
            vld_q[i] <= vld_q[i-1];
            dat_q[i] <= dat_q[i-1];
          end
        end
      end

      assign push       = vld_q[RD_LATENCY-2];
      assign push_entry = dat_q[RD_LATENCY-2];
    end
  endgenerate

  mem_slave_rsp_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(RD_LATENCY + 1)
  ) u_rsp_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (push),
    .wdata_i(push_entry),
    .pop_i  (consume),
    .rdata_o(head_entry),
    .empty_o(fifo_empty)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_wr    = rsp_valid & head_entry[DATA_WIDTH+2];
  assign rsp_err   = rsp_valid ? head_entry[DATA_WIDTH +: 2] : 2'b00;
  assign rsp_rdata = rsp_valid ? head_entry[DATA_WIDTH-1:0] : '0;
  assign req_ready = req_ready_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_mem_slave_rsp.sv
// Scoreboard bench for mem_slave_rsp: a word-array reference model predicts each response at accept time.
module tb_mem_slave_rsp;

  localparam int  DEPTH_T  = 61;
  localparam int  RSV_LO_T = 61;
  localparam int  RSV_HI_T = 64;
`ifdef MEM_SLAVE_BYTE_STROBE_EN
  localparam bit  STRB_EN  = 1'b1;
`else
  localparam bit  STRB_EN  = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
`ifdef MEM_SLAVE_BYTE_STROBE_EN
  logic [3:0]  req_strb;
`endif
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_wr;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        init_done;

  mem_slave_rsp dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wr   (req_wr),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
`ifdef MEM_SLAVE_BYTE_STROBE_EN
    .req_strb (req_strb),
`endif
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_wr   (rsp_wr),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .init_done(init_done)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] ref_mem [1024];
  int          checks = 0;
  int          errors = 0;
  int          rsp_mode = 0;  // 0: always ready, 1: random, 2: held low

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'hFFFF_FFFF;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic wr, input logic [9:0] a, input logic [31:0] d,
                              input logic [3:0] s);
    exp_t e;
    e.wr    = wr;
    e.rdata = 32'h0;
    if (int'(a) < DEPTH_T) begin
      e.err = 2'b00;
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (!STRB_EN || s[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
      end else begin
        e.rdata = ref_mem[a];
      end
    end else if (int'(a) >= RSV_LO_T && int'(a) <= RSV_HI_T) begin
      e.err = 2'b11;
      if (!wr) e.rdata = 32'hDEAD_BEEF;
    end else begin
      e.err = wr ? 2'b01 : 2'b10;
    end
    exp_q.push_back(e);
  endtask

  task automatic drive_cycle(input logic v, input logic wr, input logic [9:0] a,
                             input logic [31:0] d, input logic [3:0] s, output bit acc);
    @(negedge clk);
    req_valid = v;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
`ifdef MEM_SLAVE_BYTE_STROBE_EN
    req_strb  = s;
`endif
    acc = v && req_ready;
    if (acc) model_accept(wr, a, d, s);
  endtask

  task automatic idle();
    bit acc;
    drive_cycle(1'b0, 1'b0, 10'd0, 32'd0, 4'd0, acc);
  endtask

  task automatic send(input logic wr, input logic [9:0] a, input logic [31:0] d,
                      input logic [3:0] s);
    bit acc = 1'b0;
    int n = 0;
    while (!acc && n < 100) begin
      drive_cycle(1'b1, wr, a, d, s, acc);
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: addr %0d not accepted after %0d cycles", a, n);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic reset_and_init(input int hold);
    int n = 0;
    int bad_rsp = 0;
    int bad_rdy = 0;
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 1'b0;
    model_reset();
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_wr",    32'(rsp_wr),    32'd0);
    check("rst_rsp_rdata", rsp_rdata,      32'd0);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    repeat (hold) @(negedge clk);
    reset = 1'b0;
    while (!init_done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (rsp_valid) bad_rsp++;
      if (req_ready && !init_done) bad_rdy++;
    end
    check("init_cycles",       32'(n),       32'd61);
    check("ready_at_init",     32'(req_ready), 32'd1);
    check("no_rsp_in_init",    32'(bad_rsp), 32'd0);
    check("no_ready_in_init",  32'(bad_rdy), 32'd0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      case (rsp_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // Monitor: a response seen valid and ready here is consumed at the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got wr=%0d err=%0d rdata=%h with nothing outstanding",
                   rsp_wr, rsp_err, rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          check("rsp_wr",    32'(rsp_wr),  32'(e.wr));
          check("rsp_err",   32'(rsp_err), 32'(e.err));
          check("rsp_rdata", rsp_rdata,    e.rdata);
        end
      end
    end
  end

  initial begin
    int          acc_n;
    bit          acc;
    logic [9:0]  a;
    logic        wr;

    reset     = 1'b1;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
`ifdef MEM_SLAVE_BYTE_STROBE_EN
    req_strb  = '0;
`endif
    rsp_ready = 1'b0;
    rsp_mode  = 0;

    reset_and_init(3);

    send(1'b0, 10'd0, 32'd0, 4'hF);
    send(1'b1, 10'd5, 32'h1234_5678, 4'hF);
    send(1'b0, 10'd5, 32'd0, 4'hF);
    @(posedge clk);
    #1;
    check("rd_latency", {30'd0, rsp_valid, rsp_wr}, 32'd2);

    send(1'b1, 10'd61,   32'h0BAD_F00D, 4'hF);
    send(1'b0, 10'd61,   32'd0, 4'hF);
    send(1'b1, 10'd64,   32'h0BAD_F00D, 4'hF);
    send(1'b0, 10'd64,   32'd0, 4'hF);
    send(1'b0, 10'd0,    32'd0, 4'hF);
    send(1'b1, 10'd60,   32'hCAFE_0060, 4'hF);
    send(1'b0, 10'd60,   32'd0, 4'hF);
    send(1'b1, 10'd65,   32'h6565_6565, 4'hF);
    send(1'b0, 10'd65,   32'd0, 4'hF);
    send(1'b0, 10'd1,    32'd0, 4'hF);
    send(1'b1, 10'd1023, 32'h1111_2222, 4'hF);
    send(1'b0, 10'd1023, 32'd0, 4'hF);
    send(1'b1, 10'd3,    32'hAABB_CCDD, 4'b0101);
    send(1'b0, 10'd3,    32'd0, 4'hF);
    idle();
    wait_drain();

    rsp_mode = 2;
    repeat (2) @(negedge clk);
    acc_n = 0;
    for (int i = 0; i < 6; i++) begin
      a  = 10'($urandom_range(0, 70));
      wr = 1'($urandom_range(0, 1));
      drive_cycle(1'b1, wr, a, $urandom, 4'($urandom_range(0, 15)), acc);
      if (acc) acc_n++;
    end
    check("bp_accepts",   32'(acc_n),     32'd2);
    check("bp_ready_low", 32'(req_ready), 32'd0);
    idle();
    rsp_mode = 0;
    wait_drain();

    rsp_mode = 1;
    for (int i = 0; i < 250; i++) begin
      a = $urandom_range(0, 1) ? 10'($urandom_range(0, 70)) : 10'($urandom_range(0, 1023));
      send(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    wait_drain();

    rsp_mode = 2;
    repeat (2) @(negedge clk);
    send(1'b1, 10'd7, 32'h0000_0055, 4'hF);
    send(1'b0, 10'd7, 32'd0, 4'hF);
    idle();
    @(negedge clk);
    #1;
    check("pre_reset_rsp_valid", 32'(rsp_valid), 32'd1);
    rsp_mode = 0;
    reset_and_init(2);
    send(1'b0, 10'd7, 32'd0, 4'hF);
    send(1'b0, 10'd5, 32'd0, 4'hF);
    idle();
    wait_drain();
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
